apb_reduce_master: RTL and testbench
====================================

// Module: apb_reduce_master
// PURPOSE
//  APB read master that fetches NUM_OPS consecutive operands from an APB slave when requested.
//  It reduces them with a selectable operator (sum/xor/max/min) and returns one registered result.
//  Sits between a compute requester and the APB slave memory.
//  Adds over the previous generation: configurable width/depth/base/stride, PSLVERR handling, wait timeout.
// PARAMETERS
//  DATA_W     32  APB data width (prdata, operands)
//  ADDR_W     8   APB address width
//  NUM_OPS    2   operands per request, >=2
//  ADDR_STEP  1   address increment between operands
//  TIMEOUT    16  max consecutive ACCESS cycles with pready=0 before abort, >=1
//  ACC_W      DATA_W+$clog2(NUM_OPS)  result width (derived, localparam)
// PORTS
//  pclk         in   1       APB clock, all logic rising-edge
//  presetn      in   1       async active-low reset
//  compute_req  in   1       start request, sampled only in IDLE
//  base_addr    in   ADDR_W  first operand address, latched with compute_req
//  mode         in   2       00 sum, 01 xor, 10 unsigned max, 11 unsigned min; latched with compute_req
//  busy         out  1       1 whenever state != IDLE
//  psel         out  1       APB select
//  penable      out  1       APB enable
//  pwrite       out  1       constant 0 (read-only master)
//  paddr        out  ADDR_W  APB address
//  pwdata       out  DATA_W  constant 0
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB ready
//  pslverr      in   1       APB slave error, valid with pready in ACCESS
//  datao        out  ACC_W   result, registered, held until the next successful result
//  valido       out  1       one-cycle pulse: datao updated
//  erro         out  1       one-cycle pulse: request aborted (pslverr or timeout)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (datao, valido, erro, psel, penable, paddr); idx, acc, wait_cnt 0.
//  States: IDLE, SETUP, ACCESS, DONE.
//   IDLE   -> SETUP on compute_req; latch base_addr, mode; idx=0, acc=0.
//   SETUP  -> ACCESS unconditionally; psel=1, penable=0.
//   ACCESS: psel=1, penable=1.
//     pready=0: stay; wait_cnt++. When wait_cnt reaches TIMEOUT-1 and pready is still 0 -> IDLE, erro=1 next cycle.
//     pready=1 with pslverr=1: operand discarded -> IDLE; erro pulse next cycle; datao unchanged.
//     pready=1 with pslverr=0: fold prdata into acc, wait_cnt=0.
//       If idx<NUM_OPS-1: idx++ -> SETUP (no idle gap between transfers).
//       Else -> DONE.
//   DONE: datao<=acc, valido=1 for exactly this one registered cycle; psel=0 -> IDLE.
//  paddr = base + idx*ADDR_STEP, modulo 2^ADDR_W (wraps silently). paddr is 0 in IDLE and DONE.
//  Fold: first operand (idx=0) loads acc = zero-extended prdata in all modes.
//    Later operands: sum: acc + zext(prdata), never overflows ACC_W.
//    Later operands: xor/max/min operate on the low DATA_W bits; upper bits stay 0.
//  Latency, pready always 1: 2*NUM_OPS cycles from the SETUP entry to DONE; valido asserts in the cycle after the last ACCESS.
//  compute_req while busy: ignored, not queued.
//  Reset mid-transfer: immediate IDLE, bus released, no valido/erro.
//  valido and erro are never asserted in the same cycle.
// TESTING
//  1. NUM_OPS=2, base=0x10, sum, slave [0x10]=5, [0x11]=7, pready=1 -> paddr 0x10,0x11; valido pulse 5 cycles after req; datao=12.
//  2. NUM_OPS=4, sum, all operands 0xFFFFFFFF -> datao=0x3_FFFF_FFFC (ACC_W=34), no truncation.
//  3. base=0xFE, ADDR_STEP=1, NUM_OPS=4 -> paddr sequence 0xFE,0xFF,0x00,0x01.
//  4. mode=max, operands 3,9,4 (NUM_OPS=3) -> datao=9; mode=min -> datao=3; mode=xor 3^9^4 -> datao=0xE.
//  5. pslverr=1 on the 2nd operand -> erro pulse, valido=0, datao keeps previous value; TIMEOUT=4, pready held low -> erro after 4 ACCESS cycles, psel=0.
//  6. Extra compute_req while busy -> exactly one result; presetn low mid-ACCESS -> psel=penable=0 at once, no pulses.

Source files
------------

// File: rtl/apb_reduce_master.sv
// APB read master: fetches NUM_OPS operands and reduces them
// with sum/xor/max/min into one registered result.
module apb_reduce_master #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int NUM_OPS   = 2,
  parameter int ADDR_STEP = 1,
  parameter int TIMEOUT   = 16,
  localparam int ACC_W    = DATA_W + $clog2(NUM_OPS)
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              compute_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [ACC_W-1:0]  datao,
  output logic              valido,
  output logic              erro
);

  localparam int IDX_W = $clog2(NUM_OPS);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        mode_q, mode_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [ACC_W-1:0]  datao_q, datao_d;
  logic              valido_q, valido_d;
  logic              erro_q, erro_d;

  logic [ACC_W-1:0]  fold;
  logic [DATA_W-1:0] lo;
  logic [ADDR_W-1:0] addr_c;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      mode_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      wait_q   <= '0;
      datao_q  <= '0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      wait_q   <= wait_d;
      datao_q  <= datao_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
    end
  end

  // First operand always loads; later ones combine per mode
  always_comb begin
    lo   = acc_q[DATA_W-1:0];
    fold = ACC_W'(prdata);
    if (idx_q != '0) begin
      unique case (mode_q)
        2'b00: fold = acc_q + ACC_W'(prdata);
        2'b01: fold = ACC_W'(lo ^ prdata);
        2'b10: fold = ACC_W'((prdata > lo) ? prdata : lo);
        2'b11: fold = ACC_W'((prdata < lo) ? prdata : lo);
      endcase
    end
  end

  assign addr_c = base_q
    + ADDR_W'(ADDR_W'(idx_q) * ADDR_W'(ADDR_STEP));

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    wait_d   = wait_q;
    datao_d  = datao_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (compute_req) begin
          state_d = S_SETUP;
          base_d  = base_addr;
          mode_d  = mode;
          idx_d   = '0;
          acc_d   = '0;
          wait_d  = '0;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (!pready) begin
          if (wait_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            erro_d  = 1'b1;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else if (pslverr) begin
          state_d = S_IDLE;
          erro_d  = 1'b1;
          wait_d  = '0;
        end else begin
          acc_d  = fold;
          wait_d = '0;
          if (idx_q < IDX_W'(NUM_OPS - 1)) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d  = S_DONE;
            datao_d  = fold;
            valido_d = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable = (state_q == S_ACCESS);
  assign paddr   = psel ? addr_c : '0;
  assign pwrite  = 1'b0;
  assign pwdata  = '0;
  assign datao   = datao_q;
  assign valido  = valido_q;
  assign erro    = erro_q;

endmodule

// File: tb/tb_apb_reduce_master.sv
// Directed bench for apb_reduce_master: three instances cover
// NUM_OPS=2 (TIMEOUT=4), NUM_OPS=4 and NUM_OPS=3.
module tb_apb_reduce_master;

  logic        clk;
  logic        rstn;
  logic [7:0]  base;
  logic [1:0]  mode;
  logic        pready;
  logic        pslverr;
  logic        err_en;
  logic [7:0]  err_addr;
  logic [31:0] mem [256];

  logic        req_a, busy_a, psel_a, pen_a, pw_a;
  logic [7:0]  pa_a;
  logic [31:0] pwd_a, prd_a;
  logic [32:0] dat_a;
  logic        val_a, err_a;

  logic        req_b, busy_b, psel_b, pen_b, pw_b;
  logic [7:0]  pa_b;
  logic [31:0] pwd_b, prd_b;
  logic [33:0] dat_b;
  logic        val_b, err_b;

  logic        req_c, busy_c, psel_c, pen_c, pw_c;
  logic [7:0]  pa_c;
  logic [31:0] pwd_c, prd_c;
  logic [33:0] dat_c;
  logic        val_c, err_c;

  int checks = 0;
  int errors = 0;
  int n, nacc, nval, nerr;
  logic [7:0] ad [8];

  assign prd_a = mem[pa_a];
  assign prd_b = mem[pa_b];
  assign prd_c = mem[pa_c];
  assign pslverr = err_en && psel_a && (pa_a == err_addr);

  apb_reduce_master #(.NUM_OPS(2), .TIMEOUT(4)) dut_a (
    .pclk(clk), .presetn(rstn), .compute_req(req_a),
    .base_addr(base), .mode(mode), .busy(busy_a),
    .psel(psel_a), .penable(pen_a), .pwrite(pw_a),
    .paddr(pa_a), .pwdata(pwd_a), .prdata(prd_a),
    .pready(pready), .pslverr(pslverr), .datao(dat_a),
    .valido(val_a), .erro(err_a)
  );

  apb_reduce_master #(.NUM_OPS(4)) dut_b (
    .pclk(clk), .presetn(rstn), .compute_req(req_b),
    .base_addr(base), .mode(mode), .busy(busy_b),
    .psel(psel_b), .penable(pen_b), .pwrite(pw_b),
    .paddr(pa_b), .pwdata(pwd_b), .prdata(prd_b),
    .pready(pready), .pslverr(1'b0), .datao(dat_b),
    .valido(val_b), .erro(err_b)
  );

  apb_reduce_master #(.NUM_OPS(3)) dut_c (
    .pclk(clk), .presetn(rstn), .compute_req(req_c),
    .base_addr(base), .mode(mode), .busy(busy_c),
    .psel(psel_c), .penable(pen_c), .pwrite(pw_c),
    .paddr(pa_c), .pwdata(pwd_c), .prdata(prd_c),
    .pready(pready), .pslverr(1'b0), .datao(dat_c),
    .valido(val_c), .erro(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [7:0] b, input logic [1:0] m);
    base = b; mode = m; req_a = 1'b1;
    n = 0; nacc = 0; nval = 0; nerr = 0;
    do begin
      step(); req_a = 1'b0; n++;
      if (psel_a && pen_a) begin
        if (nacc < 8) ad[nacc] = pa_a;
        nacc++;
      end
      if (val_a) nval++;
      if (err_a) nerr++;
    end while (!val_a && !err_a && n < 30);
  endtask

  task automatic run_b(input logic [7:0] b, input logic [1:0] m);
    base = b; mode = m; req_b = 1'b1;
    n = 0; nacc = 0; nval = 0; nerr = 0;
    do begin
      step(); req_b = 1'b0; n++;
      if (psel_b && pen_b) begin
        if (nacc < 8) ad[nacc] = pa_b;
        nacc++;
      end
      if (val_b) nval++;
      if (err_b) nerr++;
    end while (!val_b && !err_b && n < 30);
  endtask

  task automatic run_c(input logic [7:0] b, input logic [1:0] m);
    base = b; mode = m; req_c = 1'b1;
    n = 0; nacc = 0; nval = 0; nerr = 0;
    do begin
      step(); req_c = 1'b0; n++;
      if (val_c) nval++;
      if (err_c) nerr++;
    end while (!val_c && !err_c && n < 30);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(); step();
    checks++;
    if ({busy_a, psel_a, pen_a, pa_a, val_a, err_a} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0",
        {busy_a, psel_a, pen_a, pa_a, val_a, err_a});
    end
    checks++;
    if (dat_a !== 33'd0 || dat_b !== 34'd0) begin
      errors++;
      $display("FAIL reset_datao got %h/%h want 0", dat_a, dat_b);
    end
    checks++;
    if (pw_a !== 1'b0 || pwd_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_pw got %b/%h want 0", pw_a, pwd_a);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_sum_latency();
    mem[8'h10] = 32'd5;
    mem[8'h11] = 32'd7;
    run_a(8'h10, 2'b00);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL sum_latency got %0d want 5", n);
    end
    checks++;
    if (ad[0] !== 8'h10 || ad[1] !== 8'h11 || nacc !== 2) begin
      errors++;
      $display("FAIL sum_paddr got %h,%h n=%0d want 10,11 n=2",
        ad[0], ad[1], nacc);
    end
    checks++;
    if (dat_a !== 33'd12 || nval !== 1) begin
      errors++;
      $display("FAIL sum_datao got %0d want 12", dat_a);
    end
    checks++;
    if (pa_a !== 8'h00 || psel_a !== 1'b0) begin
      errors++;
      $display("FAIL done_bus got %h/%b want 0/0", pa_a, psel_a);
    end
    step();
    checks++;
    if (val_a !== 1'b0 || dat_a !== 33'd12 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL sum_pulse got v=%b d=%0d b=%b want 0,12,0",
        val_a, dat_a, busy_a);
    end
  endtask

  task automatic test_wide_sum();
    for (int i = 0; i < 4; i++) mem[8'h20 + i] = 32'hFFFF_FFFF;
    run_b(8'h20, 2'b00);
    checks++;
    if (dat_b !== 34'h3_FFFF_FFFC || nval !== 1) begin
      errors++;
      $display("FAIL wide_sum got %h want 3fffffffc", dat_b);
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL wide_latency got %0d want 9", n);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [7:0] exp [4];
    exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'h01;
    mem[8'hFE] = 32'd1; mem[8'hFF] = 32'd2;
    mem[8'h00] = 32'd3; mem[8'h01] = 32'd4;
    run_b(8'hFE, 2'b00);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ad[i] !== exp[i]) begin
        errors++;
        $display("FAIL wrap_paddr%0d got %h want %h", i, ad[i], exp[i]);
      end
    end
    checks++;
    if (dat_b !== 34'd10) begin
      errors++;
      $display("FAIL wrap_sum got %0d want 10", dat_b);
    end
    step();
  endtask

  task automatic test_modes();
    logic [1:0]  md [4];
    logic [33:0] ex [4];
    md[0] = 2'b10; ex[0] = 34'd9;
    md[1] = 2'b11; ex[1] = 34'd3;
    md[2] = 2'b01; ex[2] = 34'hE;
    md[3] = 2'b00; ex[3] = 34'd16;
    mem[8'h40] = 32'd3; mem[8'h41] = 32'd9; mem[8'h42] = 32'd4;
    for (int i = 0; i < 4; i++) begin
      run_c(8'h40, md[i]);
      checks++;
      if (dat_c !== ex[i] || nval !== 1) begin
        errors++;
        $display("FAIL mode%0d got %h want %h", md[i], dat_c, ex[i]);
      end
      step();
    end
  endtask

  task automatic test_slverr();
    err_addr = 8'h11; err_en = 1'b1;
    run_a(8'h10, 2'b00);
    err_en = 1'b0;
    checks++;
    if (nerr !== 1 || nval !== 0) begin
      errors++;
      $display("FAIL slverr_pulse got e=%0d v=%0d want 1,0", nerr, nval);
    end
    checks++;
    if (dat_a !== 33'd12) begin
      errors++;
      $display("FAIL slverr_datao got %0d want 12", dat_a);
    end
    step();
    checks++;
    if (err_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL slverr_end got e=%b b=%b want 0,0", err_a, busy_a);
    end
  endtask

  task automatic test_timeout();
    pready = 1'b0;
    run_a(8'h10, 2'b00);
    checks++;
    if (nerr !== 1 || nval !== 0) begin
      errors++;
      $display("FAIL tmo_pulse got e=%0d v=%0d want 1,0", nerr, nval);
    end
    checks++;
    if (nacc !== 4) begin
      errors++;
      $display("FAIL tmo_cycles got %0d want 4", nacc);
    end
    checks++;
    if (psel_a !== 1'b0 || pen_a !== 1'b0) begin
      errors++;
      $display("FAIL tmo_bus got %b%b want 00", psel_a, pen_a);
    end
    pready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int cnt;
    cnt = 0;
    base = 8'h10; mode = 2'b00; req_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 2) req_a = 1'b0;
      if (val_a) cnt++;
    end
    checks++;
    if (cnt !== 1) begin
      errors++;
      $display("FAIL busy_req got %0d results want 1", cnt);
    end
    checks++;
    if (dat_a !== 33'd12) begin
      errors++;
      $display("FAIL busy_datao got %0d want 12", dat_a);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    base = 8'h10; mode = 2'b00; req_a = 1'b1;
    step(); req_a = 1'b0;
    step();
    checks++;
    if (pen_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_access got %b want 1", pen_a);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({psel_a, pen_a, busy_a} !== 3'b000) begin
      errors++;
      $display("FAIL mid_release got %b want 000",
        {psel_a, pen_a, busy_a});
    end
    step();
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (val_a || err_a) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL mid_pulses got %0d want 0", cnt);
    end
    checks++;
    if (busy_a !== 1'b0 || dat_a !== 33'd0) begin
      errors++;
      $display("FAIL mid_state got b=%b d=%0d want 0,0", busy_a, dat_a);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rstn = 1'b0; base = '0; mode = '0;
    pready = 1'b1; err_en = 1'b0; err_addr = '0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    test_reset();
    test_sum_latency();
    test_wide_sum();
    test_wrap();
    test_modes();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
